// File: rtl/dm_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and sizing helpers.
package dm_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

  // Wide enough for the largest supported memory latency (7).
  localparam int LAT_W = 3;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dm_arbiter_rr_picker.sv
// Combinational round-robin search: first set request bit after ptr, wrapping around.
module dm_arbiter_rr_picker
  import dm_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] winner_o
);

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return IDX_W'(s);
  endfunction

  // Scan from the farthest offset down so the nearest requester after ptr overwrites last.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req_i[wrap_add(ptr_i, k)]) begin
        valid_o  = 1'b1;
        winner_o = wrap_add(ptr_i, k);
      end
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between N_REQ requesters.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ-1:0]          we_i,
  input  logic [N_REQ*ADDR_W-1:0]   addr_i,
  input  logic [N_REQ*DATA_W-1:0]   wdata_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [N_REQ-1:0]          done_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      mem_en_o,
  output logic                      mem_we_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  input  logic [DATA_W-1:0]         mem_rdata_i
);

  localparam int                IDX_W    = idx_width(N_REQ);
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(MEM_LAT);
  localparam logic [IDX_W-1:0]  PTR_RST  = IDX_W'(N_REQ - 1);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 we_q, we_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic [N_REQ-1:0]     done_q, done_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;

  logic [ADDR_W-1:0]    addr_arr  [N_REQ];
  logic [DATA_W-1:0]    wdata_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign addr_arr[gi]  = addr_i[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = wdata_i[gi*DATA_W +: DATA_W];
  end

  dm_arbiter_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .valid_o  (pick_valid),
    .winner_o (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= PTR_RST;
      idx_q       <= '0;
      we_q        <= 1'b0;
      lat_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      we_q        <= we_d;
      lat_q       <= lat_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // mem_en/mem_we are launched on the grant edge so they are high during the ACCESS cycle.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    we_d        = we_q;
    lat_d       = lat_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    rdata_d     = rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (pick_valid) begin
          ptr_d           = pick_idx;
          idx_d           = pick_idx;
          we_d            = we_i[pick_idx];
          mem_addr_d      = addr_arr[pick_idx];
          mem_wdata_d     = wdata_arr[pick_idx];
          gnt_d[pick_idx] = 1'b1;
          mem_en_d        = 1'b1;
          mem_we_d        = we_i[pick_idx];
          state_d         = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        lat_d   = LAT_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_q == LAT_W'(1)) begin
          if (!we_q) rdata_d = mem_rdata_i;
          done_d[idx_q] = 1'b1;
          state_d       = ST_RESP;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      ST_RESP: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign rdata_o     = rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: transaction-level model compared every cycle plus directed literal checks.
module tb_dm_arbiter;

  localparam int N = 4;
  localparam int L = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, we, gnt, done;
  logic [63:0] addr, wdata;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_we;

  logic [3:0]  req3, we3, gnt3, done3;
  logic [63:0] addr3, wdata3;
  logic [15:0] rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic        mem_en3, mem_we3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  initial forever #5 clk = ~clk;

  dm_arbiter #(.N_REQ(4), .ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .done_o(done), .rdata_o(rdata), .mem_en_o(mem_en), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  dm_arbiter #(.N_REQ(4), .ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_i(req3), .we_i(we3), .addr_i(addr3), .wdata_i(wdata3),
    .gnt_o(gnt3), .done_o(done3), .rdata_o(rdata3), .mem_en_o(mem_en3), .mem_we_o(mem_we3),
    .mem_addr_o(mem_addr3), .mem_wdata_o(mem_wdata3), .mem_rdata_i(mem_rdata3)
  );

  function automatic logic [15:0] ram_init(input logic [7:0] a);
    return (a == 8'h10) ? 16'hBEEF : {8'hA5, a};
  endfunction

  // Registered RAM (1-cycle latency) behind the MEM_LAT=1 arbiter.
  logic [15:0] ram [256];
  bit          ram_vld [256];
  logic [15:0] rd_q;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr[7:0]]     <= mem_wdata;
        ram_vld[mem_addr[7:0]] <= 1'b1;
      end else begin
        rd_q <= ram_vld[mem_addr[7:0]] ? ram[mem_addr[7:0]] : ram_init(mem_addr[7:0]);
      end
    end
  end
  assign mem_rdata = rd_q;

  // Read-only memory with a 3-stage output pipeline for the MEM_LAT=3 arbiter.
  logic [15:0] p0, p1, p2;
  always @(posedge clk) begin
    if (mem_en3) p0 <= ram_init(mem_addr3[7:0]);
    p1 <= p0;
    p2 <= p1;
  end
  assign mem_rdata3 = p2;

  // Transaction-level model state.
  bit          m_busy  = 1'b0;
  int          m_t     = 0;
  int          m_ptr   = N - 1;
  int          m_owner = 0;
  logic        m_we    = 1'b0;
  logic [15:0] m_addr  = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_rdata = '0;
  logic [15:0] sh_mem [256];
  bit          sh_vld [256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_slot(input int i, input logic w, input logic [15:0] a, input logic [15:0] d);
    we[i] = w;
    addr[i*16 +: 16]  = a;
    wdata[i*16 +: 16] = d;
  endtask

  // Run one access for requester i from an idle arbiter; returns cycles-to-done and rdata seen with done.
  task automatic access(input int i, input logic w, input logic [15:0] a, input logic [15:0] d,
                        output int n, output logic [15:0] rd);
    set_slot(i, w, a, d);
    req[i] = 1'b1;
    n = 0;
    while (done[i] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("access_timeout", 32'(n), 32'd0);
    rd = rdata;
    req[i] = 1'b0;
    $display("txn req=%0d we=%0b addr=%h wdata=%h cycles=%0d rdata=%h", i, w, a, d, n, rd);
  endtask

  initial begin
    rst_n = 1'b0;
    req = 4'hF; we = '0; addr = '0; wdata = '0;
    req3 = '0; we3 = '0; addr3 = '0; wdata3 = '0;
    fork
      // Model: advance one cycle per edge from the spec's timing rules.
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          m_busy = 1'b0; m_t = 0; m_ptr = N - 1; m_owner = 0;
          m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        end else if (m_busy) begin
          m_t++;
          if (m_t == 2 + L && !m_we)
            m_rdata = sh_vld[m_addr[7:0]] ? sh_mem[m_addr[7:0]] : ram_init(m_addr[7:0]);
          if (m_t == 3 + L) m_busy = 1'b0;
        end else if (req != 4'b0) begin
          bit found;
          found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            if (!found && req[(m_ptr + k) % N]) begin
              found   = 1'b1;
              m_owner = (m_ptr + k) % N;
            end
          end
          m_ptr   = m_owner;
          m_we    = we[m_owner];
          m_addr  = addr[m_owner*16 +: 16];
          m_wdata = wdata[m_owner*16 +: 16];
          m_busy  = 1'b1;
          m_t     = 1;
          if (m_we) begin
            sh_mem[m_addr[7:0]] = m_wdata;
            sh_vld[m_addr[7:0]] = 1'b1;
          end
        end
      end
      // Compare every cycle, mid-cycle.
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          chk("rst_gnt", 32'(gnt), 32'd0);
          chk("rst_done", 32'(done), 32'd0);
          chk("rst_mem_en", 32'(mem_en), 32'd0);
          chk("rst_rdata", 32'(rdata), 32'd0);
        end else begin
          logic [3:0] eg, ed;
          logic       ee;
          eg = m_busy ? (4'b0001 << m_owner) : 4'b0000;
          ee = m_busy && (m_t == 1);
          ed = (m_busy && (m_t == 2 + L)) ? eg : 4'b0000;
          chk("mdl_gnt", 32'(gnt), 32'(eg));
          chk("mdl_done", 32'(done), 32'(ed));
          chk("mdl_mem_en", 32'(mem_en), 32'(ee));
          chk("mdl_rdata", 32'(rdata), 32'(m_rdata));
          if (ee) begin
            chk("mdl_mem_we", 32'(mem_we), 32'(m_we));
            chk("mdl_mem_addr", 32'(mem_addr), 32'(m_addr));
            if (m_we) chk("mdl_mem_wdata", 32'(mem_wdata), 32'(m_wdata));
          end
        end
      end
      // Directed stimulus.
      begin
        int          n, owner, prev, en_cnt, done_at, seen_done;
        logic [15:0] rd;

        // Reset with all requests high.
        repeat (3) tick();
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_mem_en", 32'(mem_en), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("first_gnt", 32'(gnt), 32'b0001);
        $display("txn reset release first gnt=%b", gnt);
        req = 4'h0;
        repeat (6) tick();

        // Single read by requester 2.
        set_slot(2, 1'b0, 16'h0010, 16'h0000);
        req = 4'b0100;
        tick();
        chk("rd_mem_en_c1", 32'(mem_en), 32'd1);
        chk("rd_mem_addr_c1", 32'(mem_addr), 32'h0010);
        tick();
        chk("rd_done_c2", 32'(done), 32'd0);
        tick();
        chk("rd_done_c3", 32'(done), 32'b0100);
        chk("rd_rdata_c3", 32'(rdata), 32'hBEEF);
        $display("txn single read req=2 addr=0010 done=%b rdata=%h", done, rdata);
        req = 4'h0;
        repeat (3) tick();

        // Write by requester 1, then read back by requester 3.
        access(1, 1'b1, 16'h0020, 16'h1234, n, rd);
        chk("wr_rdata_unchanged", 32'(rd), 32'hBEEF);
        chk("wr_latency", 32'(n), 32'd3);
        repeat (3) tick();
        access(3, 1'b0, 16'h0020, 16'h0000, n, rd);
        chk("rd_after_wr", 32'(rd), 32'h1234);
        repeat (3) tick();

        // Fairness: all four requesting continuously.
        for (int i = 0; i < 4; i++) set_slot(i, 1'b0, 16'(16'h0040 + i), 16'h0000);
        req  = 4'hF;
        prev = 0;
        for (int k = 0; k < 8; k++) begin
          n = 0;
          do begin
            tick();
            n++;
          end while (done === 4'b0000 && n < 20);
          if (n >= 20) chk("fair_timeout", 32'(n), 32'd0);
          owner = -1;
          for (int b = 0; b < 4; b++) if (done[b]) owner = b;
          chk("fair_owner", 32'(owner), 32'(k % 4));
          if (k > 0) chk("fair_gap", 32'(cyc - prev), 32'd4);
          $display("txn fairness k=%0d owner=%0d cycle=%0d rdata=%h", k, owner, cyc, rdata);
          prev = cyc;
        end
        req = 4'h0;
        repeat (4) tick();

        // Abort: reset during WAIT of requester 0's read.
        set_slot(0, 1'b0, 16'h0010, 16'h0000);
        req = 4'b0001;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        req = 4'b0011;
        seen_done = 0;
        repeat (2) begin
          tick();
          if (done !== 4'b0000) seen_done++;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("abort_restart_gnt", 32'(gnt), 32'b0001);
        $display("txn abort recovery gnt=%b", gnt);
        req = 4'h0;
        repeat (5) tick();

        // MEM_LAT=3 single read on the second instance.
        addr3[15:0] = 16'h0010;
        req3 = 4'b0001;
        en_cnt  = 0;
        done_at = -1;
        rd      = '0;
        for (int c = 1; c <= 12; c++) begin
          tick();
          if (mem_en3 === 1'b1) en_cnt++;
          if (done3[0] === 1'b1 && done_at < 0) begin
            done_at = c;
            rd      = rdata3;
            req3    = 4'b0000;
          end
        end
        chk("lat3_done_cycle", 32'(done_at), 32'd5);
        chk("lat3_mem_en_cycles", 32'(en_cnt), 32'd1);
        chk("lat3_rdata", 32'(rd), 32'hBEEF);
        $display("txn mem_lat=3 read done_cycle=%0d mem_en_cycles=%0d rdata=%h", done_at, en_cnt, rd);
        repeat (2) tick();
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
